// File: rtl/mmu_tlb2l_if.sv
// mmu_tlb2l_if: CPU request/response channel and page-table read channel of the MMU.
// The MMU connects through the slave modport; the CPU/memory side uses master.
interface mmu_tlb2l_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_vaddr;
  logic        req_write;
  logic        req_exec;
  logic        req_user;
  logic        resp_valid;
  logic [31:0] resp_paddr;
  logic        resp_page_fault;
  logic        resp_prot_fault;
  logic        pt_req;
  logic [31:0] pt_addr;
  logic        pt_ack;
  logic [31:0] pt_data;

  modport slave (
    input  req_valid, req_vaddr, req_write, req_exec, req_user, pt_ack, pt_data,
    output req_ready, resp_valid, resp_paddr, resp_page_fault, resp_prot_fault,
           pt_req, pt_addr
  );

  modport master (
    output req_valid, req_vaddr, req_write, req_exec, req_user, pt_ack, pt_data,
    input  req_ready, resp_valid, resp_paddr, resp_page_fault, resp_prot_fault,
           pt_req, pt_addr
  );
endinterface

// File: rtl/mmu_tlb2l.sv
// mmu_tlb2l: 32-bit MMU with a fully associative ASID-tagged TLB and a
// two-level page table walker supporting 4 MB superpages. One translation
// is handled at a time; page-table reads use a request/ack handshake.
module mmu_tlb2l #(
  parameter int TLB_ENTRIES = 16,
  parameter int ASID_W      = 8,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mmu_enable,
  input  logic [31:0]       page_table_base,
  input  logic [ASID_W-1:0] cur_asid,
  input  logic              tlb_flush,
  input  logic              flush_asid_only,
  input  logic [ASID_W-1:0] flush_asid,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  mmu_tlb2l_if.slave        bus
);

  localparam int IDX_W = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_WALK1  = 3'd2;
  localparam logic [2:0] S_WALK2  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  // Latched request and walk context
  logic [2:0]        r_state;
  logic [31:0]       r_vaddr;
  logic              r_write;
  logic              r_exec;
  logic              r_user;
  logic [ASID_W-1:0] r_asid;
  logic [19:0]       r_l1Ppn;
  logic              r_flushSeen;
  logic [31:0]       r_paddr;
  logic              r_pageFault;
  logic              r_protFault;
  logic [CNT_W-1:0]  r_hitCnt;
  logic [CNT_W-1:0]  r_missCnt;

  // TLB storage; only the PTE fields a translation needs are kept (U/W/X and PPN)
  logic [TLB_ENTRIES-1:0] r_tValid;
  logic [TLB_ENTRIES-1:0] r_tSuper;
  logic [ASID_W-1:0]      r_tAsid [TLB_ENTRIES];
  logic [19:0]            r_tVpn  [TLB_ENTRIES];
  logic [2:0]             r_tPerm [TLB_ENTRIES];
  logic [19:0]            r_tPpn  [TLB_ENTRIES];
  logic [IDX_W-1:0]       r_rrPtr;

  logic             w_hit;
  logic [IDX_W-1:0] w_hitIdx;
  logic [IDX_W-1:0] w_victim;
  logic             w_hasFree;
  logic [31:0]      w_l1Addr;
  logic [31:0]      w_l2Addr;
  logic             w_walkLeaf;
  logic             w_walkProt;
  logic [31:0]      w_walkPaddr;
  logic             w_hitProt;
  logic [31:0]      w_hitPaddr;
  logic             w_fillEn;
  logic             w_unusedBits;

  // Permission check on a leaf; perm is {U, W, X}
  function automatic logic protViol(input logic [2:0] perm, input logic user,
                                    input logic write, input logic exec);
    return (user && !perm[2]) || (write && !perm[1]) || (exec && !perm[0]);
  endfunction

  // Physical address from a leaf PPN; superpages keep 22 offset bits
  function automatic logic [31:0] leafAddr(input logic [19:0] ppn, input logic sup,
                                           input logic [31:0] va);
    return sup ? {ppn[19:10], va[21:0]} : {ppn, va[11:0]};
  endfunction

  // Associative match against the latched vaddr and ASID
  always_comb begin
    w_hit    = 1'b0;
    w_hitIdx = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (r_tValid[i] && (r_tAsid[i] == r_asid) &&
          (r_tSuper[i] ? (r_tVpn[i][19:10] == r_vaddr[31:22])
                       : (r_tVpn[i] == r_vaddr[31:12]))) begin
        w_hit    = 1'b1;
        w_hitIdx = IDX_W'(i);
      end
    end
  end

  // Victim choice: lowest invalid entry, otherwise the round-robin pointer
  always_comb begin
    w_victim  = r_rrPtr;
    w_hasFree = 1'b0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (!r_tValid[i]) begin
        w_hasFree = 1'b1;
        w_victim  = IDX_W'(i);
      end
    end
  end

  // PTE addresses, leaf decode and fill decision for the current walk step
  always_comb begin
    w_l1Addr    = {page_table_base[31:12], 12'b0} + {20'b0, r_vaddr[31:22], 2'b00};
    w_l2Addr    = {r_l1Ppn, 12'b0} + {20'b0, r_vaddr[21:12], 2'b00};
    w_walkLeaf  = (r_state == S_WALK2) || ((r_state == S_WALK1) && bus.pt_data[27]);
    w_walkProt  = protViol(bus.pt_data[30:28], r_user, r_write, r_exec);
    w_walkPaddr = leafAddr(bus.pt_data[19:0], r_state == S_WALK1, r_vaddr);
    w_hitProt   = protViol(r_tPerm[w_hitIdx], r_user, r_write, r_exec);
    w_hitPaddr  = leafAddr(r_tPpn[w_hitIdx], r_tSuper[w_hitIdx], r_vaddr);
    w_fillEn    = ((r_state == S_WALK1) || (r_state == S_WALK2)) && bus.pt_ack &&
                  bus.pt_data[31] && w_walkLeaf && !tlb_flush && !r_flushSeen;
  end

  // TLB entries: flush clears matching entries; fills only happen when no flush is involved
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tValid <= '0;
      r_tSuper <= '0;
      r_rrPtr  <= '0;
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        r_tAsid[i] <= '0;
        r_tVpn[i]  <= '0;
        r_tPerm[i] <= '0;
        r_tPpn[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        if (tlb_flush && (!flush_asid_only || (r_tAsid[i] == flush_asid))) begin
          r_tValid[i] <= 1'b0;
        end
      end
      if (w_fillEn) begin
        r_tValid[w_victim] <= 1'b1;
        r_tSuper[w_victim] <= (r_state == S_WALK1);
        r_tAsid[w_victim]  <= r_asid;
        r_tVpn[w_victim]   <= r_vaddr[31:12];
        r_tPerm[w_victim]  <= bus.pt_data[30:28];
        r_tPpn[w_victim]   <= bus.pt_data[19:0];
        if (!w_hasFree) begin
          r_rrPtr <= r_rrPtr + IDX_W'(1);
        end
      end
    end
  end

  // Translation FSM: accept, look up, walk on miss, then a one-cycle response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_vaddr     <= '0;
      r_write     <= 1'b0;
      r_exec      <= 1'b0;
      r_user      <= 1'b0;
      r_asid      <= '0;
      r_l1Ppn     <= '0;
      r_flushSeen <= 1'b0;
      r_paddr     <= '0;
      r_pageFault <= 1'b0;
      r_protFault <= 1'b0;
      r_hitCnt    <= '0;
      r_missCnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_vaddr     <= bus.req_vaddr;
            r_write     <= bus.req_write;
            r_exec      <= bus.req_exec;
            r_user      <= bus.req_user;
            r_asid      <= cur_asid;
            r_flushSeen <= 1'b0;
            r_state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (!mmu_enable) begin
            r_paddr     <= r_vaddr;
            r_pageFault <= 1'b0;
            r_protFault <= 1'b0;
            r_state     <= S_RESP;
          end else if (w_hit) begin
            r_paddr     <= w_hitProt ? 32'h0 : w_hitPaddr;
            r_pageFault <= 1'b0;
            r_protFault <= w_hitProt;
            if (r_hitCnt != '1) r_hitCnt <= r_hitCnt + CNT_W'(1);
            r_state     <= S_RESP;
          end else begin
            if (r_missCnt != '1) r_missCnt <= r_missCnt + CNT_W'(1);
            r_state     <= S_WALK1;
          end
        end
        S_WALK1, S_WALK2: begin
          if (tlb_flush) r_flushSeen <= 1'b1;
          if (bus.pt_ack) begin
            if (!bus.pt_data[31]) begin
              r_paddr     <= 32'h0;
              r_pageFault <= 1'b1;
              r_protFault <= 1'b0;
              r_state     <= S_RESP;
            end else if (w_walkLeaf) begin
              r_paddr     <= w_walkProt ? 32'h0 : w_walkPaddr;
              r_pageFault <= 1'b0;
              r_protFault <= w_walkProt;
              r_state     <= S_RESP;
            end else begin
              r_l1Ppn <= bus.pt_data[19:0];
              r_state <= S_WALK2;
            end
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready       = rst_n && (r_state == S_IDLE);
  assign bus.resp_valid      = (r_state == S_RESP);
  assign bus.resp_paddr      = r_paddr;
  assign bus.resp_page_fault = r_pageFault;
  assign bus.resp_prot_fault = r_protFault;
  assign bus.pt_req          = (r_state == S_WALK1) || (r_state == S_WALK2);
  assign bus.pt_addr         = (r_state == S_WALK1) ? w_l1Addr :
                               (r_state == S_WALK2) ? w_l2Addr : 32'h0;
  assign hit_count           = r_hitCnt;
  assign miss_count          = r_missCnt;

  // Base offset bits and reserved PTE bits carry no meaning here
  assign w_unusedBits = ^{page_table_base[11:0], bus.pt_data[26:20]};

endmodule
